sc_frogregister: RTL

SC_FROGREGISTER -- requirements
Module: sc_frogregister

---
 rtl/sc_frogregister.sv | 115 +++++++++++
 1 files changed

// File: rtl/sc_frogregister.sv
// Frog position register for a frogger-style game: one-hot column, row, goal pulse and level count.
// Optional build macro FROGGER_WRAP_EN makes the column wrap around at both edges instead of saturating.
module sc_frogregister (
  input  logic       SC_FROGREGISTER_CLOCK_50,
  input  logic       SC_FROGREGISTER_RESET_InHigh,
  input  logic       SC_FROGREGISTER_clear_InLow,
  input  logic       SC_FROGREGISTER_init_InLow,
  input  logic       SC_FROGREGISTER_load0_InLow,
  input  logic       SC_FROGREGISTER_load1_InLow,
  input  logic [1:0] SC_FROGREGISTER_shiftselection_In,
  output logic [7:0] SC_FROGREGISTER_data_Out,
  output logic [2:0] SC_FROGREGISTER_row_Out,
  output logic       SC_FROGREGISTER_bottomsidecomparator_OutLow,
  output logic       SC_FROGREGISTER_goal_Out,
  output logic [3:0] SC_FROGREGISTER_level_Out,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GOAL = 2'd2
  } state_t;

  localparam logic [7:0] START_COL = 8'b0001_0000;
  localparam logic [2:0] TOP_ROW   = 3'd6;
  localparam logic [2:0] GOAL_ROW  = 3'd7;
  localparam logic [3:0] LEVEL_MAX = 4'd15;

  state_t     state;
  logic [7:0] data;
  logic [2:0] row;
  logic       goal;
  logic [3:0] level;

  // Edge behaviour of the column is the only thing the wrap option changes.
  function automatic logic [7:0] move_left(input logic [7:0] col);
    logic [7:0] res;
    res = col;
    if (!col[7]) res = {col[6:0], 1'b0};
`ifdef FROGGER_WRAP_EN
    else res = 8'h01;
`endif
    return res;
  endfunction

  function automatic logic [7:0] move_right(input logic [7:0] col);
    logic [7:0] res;
    res = col;
    if (!col[0]) res = {1'b0, col[7:1]};
`ifdef FROGGER_WRAP_EN
    else res = 8'h80;
`endif
    return res;
  endfunction

  always_ff @(posedge SC_FROGREGISTER_CLOCK_50 or posedge SC_FROGREGISTER_RESET_InHigh) begin
    if (SC_FROGREGISTER_RESET_InHigh) begin
      state <= IDLE;
      data  <= 8'h00;
      row   <= 3'd0;
      goal  <= 1'b0;
      level <= 4'd0;
    end else if (!SC_FROGREGISTER_clear_InLow) begin
      state <= IDLE;
      data  <= 8'h00;
      row   <= 3'd0;
      goal  <= 1'b0;
      level <= 4'd0;
    end else begin
      case (state)
        GOAL: begin
          // The goal cycle always ends with the frog back at the start.
          state <= PLAY;
          data  <= START_COL;
          row   <= 3'd0;
          goal  <= 1'b0;
        end
        default: begin
          goal <= 1'b0;
          if (!SC_FROGREGISTER_init_InLow) begin
            state <= PLAY;
            data  <= START_COL;
            row   <= 3'd0;
          end else if (state == PLAY) begin
            if (!SC_FROGREGISTER_load0_InLow) begin
              if (row == TOP_ROW) begin
                state <= GOAL;
                row   <= GOAL_ROW;
                goal  <= 1'b1;
                if (level != LEVEL_MAX) level <= level + 4'd1;
              end else begin
                row <= row + 3'd1;
              end
            end else if (!SC_FROGREGISTER_load1_InLow) begin
              if (row != 3'd0) row <= row - 3'd1;
            end else if (SC_FROGREGISTER_shiftselection_In == 2'b01) begin
              data <= move_left(data);
            end else if (SC_FROGREGISTER_shiftselection_In == 2'b10) begin
              data <= move_right(data);
            end
          end
        end
      endcase
    end
  end

  assign SC_FROGREGISTER_data_Out                    = data;
  assign SC_FROGREGISTER_row_Out                     = row;
  assign SC_FROGREGISTER_bottomsidecomparator_OutLow = |row;
  assign SC_FROGREGISTER_goal_Out                    = goal;
  assign SC_FROGREGISTER_level_Out                   = level;
  assign dbg_state                                   = state;

endmodule
